// File: rtl/spi_slave_bridge.sv
// SPI target-side bridge, fully in the clk domain: oversampled sclk/cs_n/mosi,
// configurable word width, SPI mode and bit order, back-to-back words per frame.
module spi_slave_bridge #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_load,
  output logic              frame_err,
  output logic              busy
);

  localparam int   CW        = $clog2(DATA_W + 1);
  localparam logic SCLK_IDLE = (CPOL != 0);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync, r_vld_pipe;
  logic                   r_sclk_d, r_cs_d, r_armed;

  state_t            r_state;
  logic              r_busy, r_rx_valid, r_tx_load, r_frame_err, r_need_load;
  logic [CW-1:0]     r_bit_cnt;
  logic [DATA_W-1:0] r_rx_sh, r_tx_sh, r_rx_data;

  logic              w_sclk, w_cs, w_mosi;
  logic              w_rise, w_fall, w_lead, w_trail, w_sample, w_shift;
  logic              w_cs_fall, w_cs_rise;
  logic [DATA_W-1:0] w_rx_next, w_tx_adv;

  // r_vld_pipe marks when the synchroniser output reflects the pin rather than
  // its reset value, so a cs_n held low across reset release cannot look like a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_vld_pipe  <= '0;
      r_sclk_d    <= SCLK_IDLE;
      r_cs_d      <= 1'b1;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_vld_pipe  <= {r_vld_pipe[SYNC_STAGES-2:0], 1'b1};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs;
      r_armed     <= r_armed | (r_vld_pipe[SYNC_STAGES-1] & w_cs);
    end
  end

  assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];

  assign w_rise    = w_sclk & ~r_sclk_d;
  assign w_fall    = ~w_sclk & r_sclk_d;
  assign w_lead    = (CPOL != 0) ? w_fall : w_rise;
  assign w_trail   = (CPOL != 0) ? w_rise : w_fall;
  assign w_sample  = (CPHA != 0) ? w_trail : w_lead;
  assign w_shift   = (CPHA != 0) ? w_lead : w_trail;

  assign w_cs_fall = r_armed & r_cs_d & ~w_cs;
  assign w_cs_rise = w_cs & ~r_cs_d;

  // First received bit ends up at DATA_W-1 (MSB first) or at bit 0 (LSB first).
  assign w_rx_next = (MSB_FIRST != 0) ? {r_rx_sh[DATA_W-2:0], w_mosi}
                                      : {w_mosi, r_rx_sh[DATA_W-1:1]};
  assign w_tx_adv  = (MSB_FIRST != 0) ? {r_tx_sh[DATA_W-2:0], 1'b0}
                                      : {1'b0, r_tx_sh[DATA_W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_tx_load   <= 1'b0;
      r_frame_err <= 1'b0;
      r_need_load <= 1'b0;
      r_bit_cnt   <= '0;
      r_rx_sh     <= '0;
      r_tx_sh     <= '0;
      r_rx_data   <= '0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_tx_load   <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_state   <= ACTIVE;
            r_busy    <= 1'b1;
            r_bit_cnt <= '0;
            if (CPHA == 0) begin
              r_tx_sh     <= tx_data;
              r_tx_load   <= 1'b1;
              r_need_load <= 1'b0;
            end else begin
              r_need_load <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          // A cs_n rise takes priority over any sclk edge seen in the same cycle.
          if (w_cs_rise) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_bit_cnt   <= '0;
            r_need_load <= 1'b0;
            r_frame_err <= (r_bit_cnt != '0);
          end else if (w_sample) begin
            r_rx_sh <= w_rx_next;
            if (r_bit_cnt == CW'(DATA_W - 1)) begin
              r_rx_data   <= w_rx_next;
              r_rx_valid  <= 1'b1;
              r_bit_cnt   <= '0;
              r_need_load <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + CW'(1);
            end
          end else if (w_shift) begin
            if (r_need_load) begin
              r_tx_sh     <= tx_data;
              r_tx_load   <= 1'b1;
              r_need_load <= 1'b0;
            end else begin
              r_tx_sh <= w_tx_adv;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign miso      = r_busy & ((MSB_FIRST != 0) ? r_tx_sh[DATA_W-1] : r_tx_sh[0]);
  assign miso_oe   = r_busy;
  assign busy      = r_busy;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign tx_load   = r_tx_load;
  assign frame_err = r_frame_err;

endmodule
